ssd1331_init_sequencer: RTL
===========================

// Module: ssd1331_init_sequencer
// PURPOSE
// - Upstream word source for the N-bit MOSI SPI serializer. Runs the SSD1331 power-up sequence
//   (PMODEN, RES pulse, command ROM, VCCEN, display-on), then streams pixel bytes (DC=1).
// - On request, runs the power-down sequence. Clocked on the SPI clock, one domain.
// PARAMETERS
// - WIDTH        8     SPI word width; must equal serializer WIDTH
// - PWR_WAIT_CYC 20    cycles after PMODEN rises, before RES falls
// - RES_LOW_CYC  3     cycles o_RES held low
// - RES_WAIT_CYC 3     cycles after RES rises, before the first command
// - VCC_WAIT_CYC 100   cycles after VCCEN rises, before 0xAF
// - CNT_W        24    delay counter width; every *_CYC must be < 2**CNT_W
// PORTS
// - i_SCK        in  1      clock, rising edge
// - i_RST        in  1      reset, synchronous, active-high
// - i_CS         in  1      serializer chip select; high = serializer idle
// - i_MOSI_FINAL_TX in 1    serializer is shifting the last bit of the current word
// - i_PWR_OFF    in  1      one-cycle request; honoured in S_READY only
// - i_PIX_DATA   in  WIDTH  pixel byte
// - i_PIX_VALID  in  1      pixel byte valid
// - o_PIX_READY  out 1      pixel byte accepted this cycle
// - o_START/o_DATA[WIDTH]/o_DC out  word request to serializer (DC 0=cmd, 1=data)
// - o_RES        out 1      panel reset, active-low
// - o_VCCEN, o_PMODEN out 1 panel VCC / logic supply enables
// - o_READY      out 1      high in S_READY only
// BEHAVIOUR
// - Reset (any cycle, incl. mid-transfer): o_START=0, o_DATA=0, o_DC=0, o_RES=1, o_VCCEN=0,
//   o_PMODEN=0, o_READY=0, o_PIX_READY=0; FSM -> S_PWR_WAIT, counter=0, ROM index=0. Serializer shares i_RST.
// - Word accept: accept = o_START & (i_CS | i_MOSI_FINAL_TX), sampled at the rising edge.
//   o_DATA/o_DC stay stable while o_START=1 and accept=0. On accept, next word is presented
//   the following cycle, so back-to-back words have no gap (8-cycle spacing at WIDTH=8).
// - FSM:
//   S_PWR_WAIT: o_PMODEN=1; wait PWR_WAIT_CYC -> S_RES_LOW.
//   S_RES_LOW: o_RES=0 for RES_LOW_CYC -> S_RES_WAIT. S_RES_WAIT: o_RES=1, RES_WAIT_CYC -> S_INIT.
//   S_INIT: o_START=1, o_DC=0, o_DATA=ROM[idx]; idx++ on accept; after accept of idx INIT_LEN-1 -> S_VCC.
//   S_VCC: wait i_CS=1 (last word done), then o_VCCEN=1, wait VCC_WAIT_CYC -> S_DISP_ON.
//   S_DISP_ON: send 0xAF (DC=0); on accept -> S_READY (or S_CLEAR if enabled).
//   S_READY: o_READY=1; o_START=i_PIX_VALID, o_DATA=i_PIX_DATA, o_DC=1, o_PIX_READY=accept (comb).
//     i_PWR_OFF -> S_OFF_CMD next cycle; pixel accepted in that same cycle still completes.
//   S_OFF_CMD: o_PIX_READY=0; send 0xAE (DC=0); on accept -> S_OFF_VCC.
//   S_OFF_VCC: wait i_CS=1, o_VCCEN=0, wait VCC_WAIT_CYC -> S_OFF (o_PMODEN=0, terminal until reset).
// - Delay counters: count 0..N-1, exactly N cycles in state; N=0 treated as 1.
// - i_PWR_OFF outside S_READY ignored (not latched). i_PIX_VALID outside S_READY ignored, o_PIX_READY=0.
// CONFIGURATION
// - Macro OLED_CLEAR_ON_INIT_EN defined: S_DISP_ON -> S_CLEAR, sending 0x25,0x00,0x00,0x5F,0x3F
//   (DC=0, clear full 96x64 window), then S_READY. Undefined: S_DISP_ON -> S_READY directly.
// STRUCTURE
// - Package ssd1331_pkg: FSM state typedef/localparams, command constants (CMD_DISP_ON=8'hAF,
//   CMD_DISP_OFF=8'hAE, CMD_CLEAR=8'h25, CMD_UNLOCK=8'hFD), INIT_LEN=39.
// - Sub-module ssd1331_init_rom: comb idx->byte, 39 entries: FD 12 AE A0 72 A1 00 A2 00 A4 A8 3F
//   AD 8E B0 0B B1 31 B3 F0 8A 64 8B 78 8C 64 BB 3A BE 3E 87 06 81 91 82 50 83 7D 2E.
// TESTING (bench instantiates sequencer + serializer; small *_CYC values)
// - Reset release -> o_PMODEN=1 next edge; o_RES low exactly RES_LOW_CYC; 39 bytes on MOSI = ROM, DC=0.
// - Init spacing -> consecutive ROM words start exactly 8 cycles apart, o_CS stays low throughout.
// - After ROM -> o_VCCEN=1 only after o_CS high; 0xAF sent VCC_WAIT_CYC later; o_READY=1 after accept.
// - Pixels 8'hF8,8'h00 with i_PIX_VALID held -> two o_PIX_READY pulses 8 cycles apart, DC=1 on MOSI.
// - i_PWR_OFF mid-pixel -> pixel completes, 0xAE (DC=0) follows, o_VCCEN=0, then o_PMODEN=0.
// - i_RST asserted during S_INIT byte 10 -> all outputs reset values next edge; sequence restarts at idx 0.

Source files
------------

// File: rtl/ssd1331_pkg.sv
// Shared types and constants for the SSD1331 power-up / power-down sequencer.
// Optional full-screen clear after display-on: define OLED_CLEAR_ON_INIT_EN.
package ssd1331_pkg;

    typedef enum logic [3:0] {
        S_PWR_WAIT,
        S_RES_LOW,
        S_RES_WAIT,
        S_INIT,
        S_VCC,
        S_DISP_ON,
        S_CLEAR,
        S_READY,
        S_OFF_CMD,
        S_OFF_VCC,
        S_OFF
    } state_t;

    localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
    localparam logic [7:0] CMD_CLEAR    = 8'h25;
    localparam logic [7:0] CMD_UNLOCK   = 8'hFD;

    localparam int unsigned INIT_LEN  = 39;
    localparam int unsigned CLEAR_LEN = 5;
    localparam int unsigned IDX_W     = 6;

    // Clear window command: columns 0..95, rows 0..63.
    function automatic logic [7:0] clear_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            6'd0:    b = CMD_CLEAR;
            6'd1:    b = 8'h00;
            6'd2:    b = 8'h00;
            6'd3:    b = 8'h5F;
            default: b = 8'h3F;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ssd1331_init_rom.sv
// Combinational SSD1331 initialisation command table, indexed 0..INIT_LEN-1.
// Out-of-range indices return zero.
module ssd1331_init_rom
    import ssd1331_pkg::*;
(
    input  logic [IDX_W-1:0] i_IDX,
    output logic [7:0]       o_BYTE
);

    always_comb begin
        o_BYTE = '0;
        case (i_IDX)
            6'd0:    o_BYTE = CMD_UNLOCK;
            6'd1:    o_BYTE = 8'h12;
            6'd2:    o_BYTE = CMD_DISP_OFF;
            6'd3:    o_BYTE = 8'hA0;
            6'd4:    o_BYTE = 8'h72;
            6'd5:    o_BYTE = 8'hA1;
            6'd6:    o_BYTE = 8'h00;
            6'd7:    o_BYTE = 8'hA2;
            6'd8:    o_BYTE = 8'h00;
            6'd9:    o_BYTE = 8'hA4;
            6'd10:   o_BYTE = 8'hA8;
            6'd11:   o_BYTE = 8'h3F;
            6'd12:   o_BYTE = 8'hAD;
            6'd13:   o_BYTE = 8'h8E;
            6'd14:   o_BYTE = 8'hB0;
            6'd15:   o_BYTE = 8'h0B;
            6'd16:   o_BYTE = 8'hB1;
            6'd17:   o_BYTE = 8'h31;
            6'd18:   o_BYTE = 8'hB3;
            6'd19:   o_BYTE = 8'hF0;
            6'd20:   o_BYTE = 8'h8A;
            6'd21:   o_BYTE = 8'h64;
            6'd22:   o_BYTE = 8'h8B;
            6'd23:   o_BYTE = 8'h78;
            6'd24:   o_BYTE = 8'h8C;
            6'd25:   o_BYTE = 8'h64;
            6'd26:   o_BYTE = 8'hBB;
            6'd27:   o_BYTE = 8'h3A;
            6'd28:   o_BYTE = 8'hBE;
            6'd29:   o_BYTE = 8'h3E;
            6'd30:   o_BYTE = 8'h87;
            6'd31:   o_BYTE = 8'h06;
            6'd32:   o_BYTE = 8'h81;
            6'd33:   o_BYTE = 8'h91;
            6'd34:   o_BYTE = 8'h82;
            6'd35:   o_BYTE = 8'h50;
            6'd36:   o_BYTE = 8'h83;
            6'd37:   o_BYTE = 8'h7D;
            6'd38:   o_BYTE = 8'h2E;
            default: o_BYTE = '0;
        endcase
    end

endmodule

// File: rtl/ssd1331_init_sequencer.sv
// SSD1331 power sequencing and word source for an N-bit MOSI SPI serializer.
// Optional post-init screen clear: define OLED_CLEAR_ON_INIT_EN.
module ssd1331_init_sequencer
    import ssd1331_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int PWR_WAIT_CYC = 20,
    parameter int RES_LOW_CYC  = 3,
    parameter int RES_WAIT_CYC = 3,
    parameter int VCC_WAIT_CYC = 100,
    parameter int CNT_W        = 24
) (
    input  logic             i_SCK,
    input  logic             i_RST,
    input  logic             i_CS,
    input  logic             i_MOSI_FINAL_TX,
    input  logic             i_PWR_OFF,
    input  logic [WIDTH-1:0] i_PIX_DATA,
    input  logic             i_PIX_VALID,
    output logic             o_PIX_READY,
    output logic             o_START,
    output logic [WIDTH-1:0] o_DATA,
    output logic             o_DC,
    output logic             o_RES,
    output logic             o_VCCEN,
    output logic             o_PMODEN,
    output logic             o_READY
);

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'((PWR_WAIT_CYC > 0) ? PWR_WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] RSL_LAST = CNT_W'((RES_LOW_CYC  > 0) ? RES_LOW_CYC  - 1 : 0);
    localparam logic [CNT_W-1:0] RSW_LAST = CNT_W'((RES_WAIT_CYC > 0) ? RES_WAIT_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] VCC_LAST = CNT_W'((VCC_WAIT_CYC > 0) ? VCC_WAIT_CYC - 1 : 0);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc, w_cnt_last;
    logic               w_cnt_done;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_pmoden, w_pmoden_nxt;
    logic               r_vccen, w_vccen_nxt;
    logic               r_res, w_res_nxt;
    logic [7:0]         w_rom_byte;
    logic               w_start, w_dc, w_ready, w_accept;
    logic [WIDTH-1:0]   w_data;

    ssd1331_init_rom u_rom (
        .i_IDX  (r_idx),
        .o_BYTE (w_rom_byte)
    );

    // Word presented to the serializer depends on state only, keeping accept loop-free.
    always_comb begin
        w_start = 1'b0;
        w_data  = '0;
        w_dc    = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_INIT: begin
                w_start = 1'b1;
                w_data  = WIDTH'(w_rom_byte);
            end
            S_DISP_ON: begin
                w_start = 1'b1;
                w_data  = WIDTH'(CMD_DISP_ON);
            end
`ifdef OLED_CLEAR_ON_INIT_EN
            S_CLEAR: begin
                w_start = 1'b1;
                w_data  = WIDTH'(clear_byte(r_idx));
            end
`endif
            S_READY: begin
                w_ready = 1'b1;
                w_start = i_PIX_VALID;
                w_data  = i_PIX_DATA;
                w_dc    = 1'b1;
            end
            S_OFF_CMD: begin
                w_start = 1'b1;
                w_data  = WIDTH'(CMD_DISP_OFF);
            end
            default: ;
        endcase
    end

    assign w_accept = w_start & (i_CS | i_MOSI_FINAL_TX);

    always_comb begin
        case (r_state)
            S_PWR_WAIT: w_cnt_last = PWR_LAST;
            S_RES_LOW:  w_cnt_last = RSL_LAST;
            S_RES_WAIT: w_cnt_last = RSW_LAST;
            default:    w_cnt_last = VCC_LAST;
        endcase
    end

    assign w_cnt_done = (r_cnt == w_cnt_last);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_pmoden_nxt = r_pmoden;
        w_vccen_nxt  = r_vccen;
        case (r_state)
            // Counting starts once PMODEN is up, so the full wait elapses after it rises.
            S_PWR_WAIT: begin
                w_pmoden_nxt = 1'b1;
                if (r_pmoden) begin
                    if (w_cnt_done) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RES_LOW;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            S_RES_LOW: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RES_WAIT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RES_WAIT: begin
                if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_INIT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_INIT: begin
                if (w_accept) begin
                    if (r_idx == IDX_W'(INIT_LEN - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_VCC;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_VCC: begin
                if (!r_vccen) begin
                    if (i_CS) w_vccen_nxt = 1'b1;
                end else if (w_cnt_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DISP_ON;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DISP_ON: begin
                if (w_accept) begin
`ifdef OLED_CLEAR_ON_INIT_EN
                    w_state_nxt = S_CLEAR;
`else
                    w_state_nxt = S_READY;
`endif
                end
            end
`ifdef OLED_CLEAR_ON_INIT_EN
            S_CLEAR: begin
                if (w_accept) begin
                    if (r_idx == IDX_W'(CLEAR_LEN - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_READY;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
`endif
            S_READY: begin
                if (i_PWR_OFF) w_state_nxt = S_OFF_CMD;
            end
            S_OFF_CMD: begin
                if (w_accept) w_state_nxt = S_OFF_VCC;
            end
            S_OFF_VCC: begin
                if (r_vccen) begin
                    if (i_CS) w_vccen_nxt = 1'b0;
                end else if (w_cnt_done) begin
                    w_cnt_nxt    = '0;
                    w_pmoden_nxt = 1'b0;
                    w_state_nxt  = S_OFF;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_OFF: begin
                w_pmoden_nxt = 1'b0;
            end
            default: w_state_nxt = S_PWR_WAIT;
        endcase
        w_res_nxt = (w_state_nxt != S_RES_LOW);
    end

    always_ff @(posedge i_SCK) begin
        if (i_RST) begin
            r_state  <= S_PWR_WAIT;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_pmoden <= 1'b0;
            r_vccen  <= 1'b0;
            r_res    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_pmoden <= w_pmoden_nxt;
            r_vccen  <= w_vccen_nxt;
            r_res    <= w_res_nxt;
        end
    end

    assign o_START     = w_start;
    assign o_DATA      = w_data;
    assign o_DC        = w_dc;
    assign o_READY     = w_ready;
    assign o_PIX_READY = w_ready & w_accept;
    assign o_RES       = r_res;
    assign o_VCCEN     = r_vccen;
    assign o_PMODEN    = r_pmoden;

endmodule
